// File: rtl/wll_fifo_gen2.sv
// wll_fifo_gen2: single-clock first-word-fall-through FIFO with count, threshold flags,
// overflow/underflow pulses, soft clear via en and optional overwrite-oldest on full.
module wll_fifo_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter bit OVERWRITE  = 1'b1,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_ok, rd_ok, drop_old, rd_adv;

    assign empty        = count == '0;
    assign full         = count == FULL_CNT;
    assign almost_full  = count >= AF_CNT;
    assign almost_empty = count <= AE_CNT;
    assign data_out     = mem[rd_ptr];

    // A read alongside a write-when-full frees the slot, so the write is always taken then.
    assign rd_ok    = rd_en && !empty;
    assign drop_old = OVERWRITE && wr_en && full && !rd_en;
    assign wr_ok    = wr_en && (!full || rd_en || OVERWRITE);
    assign rd_adv   = rd_ok || drop_old;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
            count     <= (wr_ok && !rd_adv) ? count + 1'b1 :
                         (rd_adv && !wr_ok) ? count - 1'b1 : count;
            overflow  <= wr_en && full && !rd_en;
            underflow <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && en && wr_ok) mem[wr_ptr] <= data_in;
    end
endmodule

// File: tb/tb_wll_fifo_gen2.sv
// tb_wll_fifo_gen2: directed checks on default and no-overwrite FIFOs plus a
// queue-model comparison on a 16x16 overwrite FIFO.
module tb_wll_fifo_gen2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // instance a: defaults (OVERWRITE=1)
    logic       a_en = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_cnt;

    // instance b: OVERWRITE=0
    logic       b_en = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_cnt;

    // instance c: 16 deep, 16 bits wide
    logic        c_en = 1'b1, c_wr = 1'b0, c_rd = 1'b0;
    logic [15:0] c_din = '0, c_dout;
    logic        c_empty, c_full, c_af, c_ae, c_ovf, c_unf;
    logic [4:0]  c_cnt;

    wll_fifo_gen2 u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .data_out(a_dout), .empty(a_empty), .full(a_full), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
    );

    wll_fifo_gen2 #(.OVERWRITE(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .data_out(b_dout), .empty(b_empty), .full(b_full), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
    );

    wll_fifo_gen2 #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .wr_en(c_wr), .data_in(c_din), .rd_en(c_rd),
        .data_out(c_dout), .empty(c_empty), .full(c_full), .almost_full(c_af),
        .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf), .underflow(c_unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int cnt, input logic e, input logic f,
                         input logic af, input logic ae, input logic ov, input logic un);
        chk({tag, ".count"}, 64'(a_cnt), 64'(cnt));
        chk({tag, ".empty"}, 64'(a_empty), 64'(e));
        chk({tag, ".full"}, 64'(a_full), 64'(f));
        chk({tag, ".af"}, 64'(a_af), 64'(af));
        chk({tag, ".ae"}, 64'(a_ae), 64'(ae));
        chk({tag, ".ovf"}, 64'(a_ovf), 64'(ov));
        chk({tag, ".unf"}, 64'(a_unf), 64'(un));
    endtask

    logic [15:0] q[$];
    logic        e_ovf, e_unf;
    int          wr_pct;

    initial begin
        // reset
        step();
        chk_a("a_rst", 0, 1, 0, 0, 1, 0, 0);
        chk("b_rst.empty", 64'(b_empty), 64'(1));
        chk("c_rst.count", 64'(c_cnt), 64'(0));
        rst_n = 1'b1;

        // fill default FIFO
        a_wr = 1'b1; a_din = 8'h11; step();
        chk_a("a_w1", 1, 0, 0, 0, 1, 0, 0);
        chk("a_w1.dout", 64'(a_dout), 64'h11);
        a_din = 8'h22; step();
        chk_a("a_w2", 2, 0, 0, 0, 0, 0, 0);
        a_din = 8'h33; step();
        chk_a("a_w3", 3, 0, 0, 1, 0, 0, 0);
        a_din = 8'h44; step();
        chk_a("a_w4", 4, 0, 1, 1, 0, 0, 0);
        chk("a_w4.dout", 64'(a_dout), 64'h11);
        // overwrite oldest
        a_din = 8'h55; step();
        chk_a("a_ovw", 4, 0, 1, 1, 0, 1, 0);
        chk("a_ovw.dout", 64'(a_dout), 64'h22);
        a_wr = 1'b0; step();
        chk("a_ovw_end.ovf", 64'(a_ovf), 64'(0));
        // drain
        a_rd = 1'b1;
        chk("a_d0.dout", 64'(a_dout), 64'h22);
        step(); chk("a_d1.dout", 64'(a_dout), 64'h33); chk("a_d1.count", 64'(a_cnt), 64'(3));
        step(); chk("a_d2.dout", 64'(a_dout), 64'h44);
        step(); chk("a_d3.dout", 64'(a_dout), 64'h55); chk("a_d3.ae", 64'(a_ae), 64'(1));
        step(); chk_a("a_d4", 0, 1, 0, 0, 1, 0, 0);
        // read on empty
        step(); chk_a("a_urd", 0, 1, 0, 0, 1, 0, 1);
        a_rd = 1'b0; step();
        chk("a_urd_end.unf", 64'(a_unf), 64'(0));

        // simultaneous on empty
        a_wr = 1'b1; a_rd = 1'b1; a_din = 8'hA5; step();
        chk_a("a_sim_e", 1, 0, 0, 0, 1, 0, 1);
        chk("a_sim_e.dout", 64'(a_dout), 64'hA5);
        a_wr = 1'b0; step();
        chk_a("a_pop", 0, 1, 0, 0, 1, 0, 0);
        step();
        chk_a("a_urd2", 0, 1, 0, 0, 1, 0, 1);
        a_rd = 1'b0;

        // soft clear with count=2
        a_wr = 1'b1; a_din = 8'h01; step();
        a_din = 8'h02; step();
        chk("a_pre_clr.count", 64'(a_cnt), 64'(2));
        a_wr = 1'b0; a_en = 1'b0; step();
        chk_a("a_clr", 0, 1, 0, 0, 1, 0, 0);
        a_en = 1'b1; a_wr = 1'b1; a_din = 8'h77; step();
        chk("a_clr_w.dout", 64'(a_dout), 64'h77);
        chk("a_clr_w.count", 64'(a_cnt), 64'(1));
        a_wr = 1'b0;

        // mid-operation reset
        rst_n = 1'b0; a_wr = 1'b1; a_din = 8'h99; step();
        chk_a("a_rst2", 0, 1, 0, 0, 1, 0, 0);
        rst_n = 1'b1; a_wr = 1'b0;

        // no-overwrite FIFO
        b_wr = 1'b1;
        b_din = 8'h11; step();
        b_din = 8'h22; step();
        b_din = 8'h33; step();
        b_din = 8'h44; step();
        chk("b_fill.full", 64'(b_full), 64'(1));
        b_din = 8'h55; step();
        chk("b_drop.ovf", 64'(b_ovf), 64'(1));
        chk("b_drop.count", 64'(b_cnt), 64'(4));
        chk("b_drop.dout", 64'(b_dout), 64'h11);
        b_rd = 1'b1; b_din = 8'h66; step();
        chk("b_sim_f.ovf", 64'(b_ovf), 64'(0));
        chk("b_sim_f.count", 64'(b_cnt), 64'(4));
        chk("b_sim_f.dout", 64'(b_dout), 64'h22);
        b_wr = 1'b0;
        step(); chk("b_d1.dout", 64'(b_dout), 64'h33);
        step(); chk("b_d2.dout", 64'(b_dout), 64'h44);
        step(); chk("b_d3.dout", 64'(b_dout), 64'h66);
        step(); chk("b_d4.empty", 64'(b_empty), 64'(1));
        b_rd = 1'b0;

        // 16-deep FIFO against a queue model
        for (int i = 0; i < 1000; i++) begin
            wr_pct = (i % 200 < 100) ? 75 : 25;
            c_wr = $urandom_range(0, 99) < wr_pct;
            c_rd = $urandom_range(0, 99) < 50;
            c_din = 16'($urandom);
            e_ovf = c_wr && q.size() == 16 && !c_rd;
            e_unf = c_rd && q.size() == 0;
            if (c_rd && q.size() > 0) void'(q.pop_front());
            else if (c_wr && q.size() == 16) void'(q.pop_front());
            if (c_wr) q.push_back(c_din);
            step();
            chk("c.count", 64'(c_cnt), 64'(q.size()));
            chk("c.empty", 64'(c_empty), 64'(q.size() == 0));
            chk("c.full", 64'(c_full), 64'(q.size() == 16));
            chk("c.af", 64'(c_af), 64'(q.size() >= 15));
            chk("c.ae", 64'(c_ae), 64'(q.size() <= 1));
            chk("c.ovf", 64'(c_ovf), 64'(e_ovf));
            chk("c.unf", 64'(c_unf), 64'(e_unf));
            if (q.size() > 0) chk("c.dout", 64'(c_dout), 64'(q[0]));
        end
        c_wr = 1'b0; c_rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wll_fifo_gen2.md
WLL_FIFO_GEN2 -- requirements
Module: wll_fifo_gen2

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (1..64).
REQ-002 Parameter ADDR_WIDTH, default 2, pointer width; DEPTH = 2**ADDR_WIDTH words (ADDR_WIDTH 1..10).
REQ-003 Parameter OVERWRITE, default 1, 1 = write-when-full replaces oldest word, 0 = write-when-full dropped.
REQ-004 Parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-005 Parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 en  input  1  block enable; low = synchronous soft clear.
REQ-009 wr_en  input  1  write request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 rd_en  input  1  read request (pop).
REQ-012 data_out  output  DATA_WIDTH  head-of-queue word (first-word fall-through).
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  count == DEPTH.
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 almost_empty  output  1  count <= AE_LEVEL.
REQ-017 count  output  ADDR_WIDTH+1  stored word count, 0..DEPTH.
REQ-018 overflow  output  1  one-cycle pulse: write attempted while full.
REQ-019 underflow  output  1  one-cycle pulse: read attempted while empty.

Function
REQ-020 Storage SHALL be DEPTH x DATA_WIDTH registers; wr_ptr, rd_ptr ADDR_WIDTH bits, wrap modulo DEPTH naturally.
REQ-021 count SHALL be a register; empty, full, almost_full, almost_empty SHALL be combinational decodes of registered count only.
REQ-022 data_out SHALL equal mem[rd_ptr] combinationally; value undefined-but-stable while empty (no X-gating required).
REQ-023 Accepted write (en=1, wr_en=1, not full): mem[wr_ptr] <= data_in, wr_ptr+1; visible on data_out next cycle if FIFO was empty (1-cycle write-to-read latency).
REQ-024 Accepted read (en=1, rd_en=1, not empty): rd_ptr+1; popped word is the data_out value in the same cycle.
REQ-025 Read while empty: no pointer change; underflow=1 next cycle.
REQ-026 Write while full, OVERWRITE=1: mem[wr_ptr] <= data_in, wr_ptr+1, rd_ptr+1 (oldest discarded), count unchanged, overflow=1 next cycle.
REQ-027 Write while full, OVERWRITE=0: memory and pointers unchanged, overflow=1 next cycle.
REQ-028 Simultaneous wr_en and rd_en, 0 < count < DEPTH: both accepted, count unchanged.
REQ-029 Simultaneous, empty: write accepted, read rejected with underflow pulse, count -> 1.
REQ-030 Simultaneous, full: read and write both accepted (no overflow pulse, either OVERWRITE), count unchanged.
REQ-031 count arithmetic: +1 on write-only accepted, -1 on read-only accepted, never wraps outside 0..DEPTH.
REQ-032 overflow/underflow SHALL be registered, high exactly one cycle per offending request, low otherwise.
REQ-033 en=0 SHALL, at the next edge, zero wr_ptr, rd_ptr, count, overflow, underflow and ignore wr_en/rd_en; memory contents not cleared.

Reset
REQ-034 rst_n=0 at a rising edge SHALL set wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0; thus empty=1, full=0, almost_empty=1, almost_full=0.
REQ-035 Reset SHALL take priority over en and all requests; asserting mid-operation discards contents logically (count=0) in the same edge.
REQ-036 Memory array SHALL NOT be reset.

Verification
REQ-037 Defaults: reset, write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1 after 3rd write; data_out=0x11.
REQ-038 From REQ-037 state, OVERWRITE=1, write 0x55 -> overflow pulse, count=4, data_out=0x22; drain reads 0x22,0x33,0x44,0x55 then empty=1.
REQ-039 OVERWRITE=0, full with 0x11..0x44, write 0x55 -> overflow pulse, drain reads 0x11..0x44.
REQ-040 Empty, wr_en=rd_en=1 with 0xA5 -> underflow pulse, count=1, data_out=0xA5; then read on empty -> underflow pulse, count=0.
REQ-041 Count=2, drop en for one cycle -> count=0, empty=1, next write 0x77 lands at address 0 and appears on data_out.
REQ-042 ADDR_WIDTH=4, DATA_WIDTH=16: 1000 random wr/rd cycles against reference queue model -> data_out, count and all flags match every cycle.
